// File: rtl/muldiv_pkg.sv
// Shared types, constants and helpers for the iterative multiply/divide unit.
package muldiv_pkg;

  localparam int WIDTH = 32;
  localparam int ITER  = WIDTH;
  localparam int CNT_W = $clog2(ITER);

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  // Absolute value for signed ops, raw value for unsigned ones.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                 input logic is_signed);
    return (is_signed && v[WIDTH-1]) ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/muldiv_sequencer_if.sv
// Pipeline-facing bus of the multiply/divide unit: issue, HI/LO access and status.
interface muldiv_sequencer_if;
  import muldiv_pkg::*;

  logic             start_i;
  op_t              op_i;
  logic [WIDTH-1:0] rs_i;
  logic [WIDTH-1:0] rt_i;
  logic             rd_hi_i;
  logic             rd_lo_i;
  logic             wr_hi_i;
  logic             wr_lo_i;
  logic [WIDTH-1:0] wdata_i;
  logic [WIDTH-1:0] hi_o;
  logic [WIDTH-1:0] lo_o;
  logic             busy_o;
  logic             done_o;
  logic             stall_o;

  modport master (
    output start_i, op_i, rs_i, rt_i, rd_hi_i, rd_lo_i, wr_hi_i, wr_lo_i, wdata_i,
    input  hi_o, lo_o, busy_o, done_o, stall_o
  );

  modport slave (
    input  start_i, op_i, rs_i, rt_i, rd_hi_i, rd_lo_i, wr_hi_i, wr_lo_i, wdata_i,
    output hi_o, lo_o, busy_o, done_o, stall_o
  );

endinterface

// File: rtl/muldiv_step.sv
// One iteration of the magnitude datapath: shift-add for multiply,
// shift-subtract-restore for divide. The accumulator carries one spare top
// bit so the multiply carry and the shifted partial remainder both fit.
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH:0] acc,
  input  logic [WIDTH-1:0] opb,
  input  logic             is_div,
  output logic [2*WIDTH:0] acc_next
);

  logic [WIDTH:0]   sum;
  logic [2*WIDTH:0] shifted;
  logic [WIDTH+1:0] diff;

  // Next accumulator for the selected op class.
  always_comb begin
    sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opb};
    shifted  = {acc[2*WIDTH-1:0], 1'b0};
    diff     = {1'b0, shifted[2*WIDTH:WIDTH]} - {2'b00, opb};
    acc_next = '0;
    if (is_div) begin
      if (!diff[WIDTH+1]) begin
        acc_next = {diff[WIDTH:0], shifted[WIDTH-1:1], 1'b1};
      end else begin
        acc_next = shifted;
      end
    end else begin
      if (acc[0]) begin
        acc_next = {1'b0, sum, acc[WIDTH-1:1]};
      end else begin
        acc_next = {1'b0, acc[2*WIDTH:1]};
      end
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO. Operands are reduced to
// magnitudes at issue, iterated for WIDTH cycles, then sign-corrected in FIX.
module muldiv_sequencer
  import muldiv_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  muldiv_sequencer_if.slave bus
);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [2*WIDTH:0] acc;
  logic [2*WIDTH:0] acc_next;
  logic [WIDTH-1:0] opb;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             op_div;
  logic             sign_a;
  logic             sign_b;
  logic             done;
  logic             busy;
  logic             start_div;
  logic             start_signed;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0] quot;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] res_hi;
  logic [WIDTH-1:0] res_lo;

  assign start_div    = (bus.op_i == OP_DIV)  || (bus.op_i == OP_DIVU);
  assign start_signed = (bus.op_i == OP_MULT) || (bus.op_i == OP_DIV);

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .acc      (acc),
    .opb      (opb),
    .is_div   (op_div),
    .acc_next (acc_next)
  );

  // Sign correction of the finished magnitude result into HI/LO values.
  always_comb begin
    prod   = acc[2*WIDTH-1:0];
    quot   = acc[WIDTH-1:0];
    rem    = acc[2*WIDTH-1:WIDTH];
    res_hi = '0;
    res_lo = '0;
    if (op_div) begin
      if (sign_a ^ sign_b) quot = ~quot + 1'b1;
      if (sign_a)          rem  = ~rem + 1'b1;
      res_hi = rem;
      res_lo = quot;
    end else begin
      if (sign_a ^ sign_b) prod = ~prod + 1'b1;
      res_hi = prod[2*WIDTH-1:WIDTH];
      res_lo = prod[WIDTH-1:0];
    end
  end

  // Sequencer FSM, HI/LO registers and the done pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      acc    <= '0;
      opb    <= '0;
      op_div <= 1'b0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      hi     <= '0;
      lo     <= '0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.wr_hi_i) hi <= bus.wdata_i;
          if (bus.wr_lo_i) lo <= bus.wdata_i;
          if (bus.start_i) begin
            op_div <= start_div;
            sign_a <= start_signed & bus.rs_i[WIDTH-1];
            sign_b <= start_signed & bus.rt_i[WIDTH-1];
            opb    <= magnitude(bus.rt_i, start_signed);
            acc    <= {{(WIDTH+1){1'b0}}, magnitude(bus.rs_i, start_signed)};
            cnt    <= '0;
            state  <= RUN;
          end
        end
        RUN: begin
          acc <= acc_next;
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(ITER - 1)) state <= FIX;
        end
        FIX: begin
          hi    <= res_hi;
          lo    <= res_lo;
          done  <= 1'b1;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign busy        = (state != IDLE);
  assign bus.hi_o    = hi;
  assign bus.lo_o    = lo;
  assign bus.busy_o  = busy;
  assign bus.done_o  = done;
  assign bus.stall_o = busy & (bus.start_i | bus.rd_hi_i | bus.rd_lo_i |
                               bus.wr_hi_i | bus.wr_lo_i);

endmodule
